uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. Captures each byte the receiver presents on its data_out/data_valid pair and stores it in a first-word-fall-through FIFO. Provides a pop interface toward the register/bus side, plus status flags: empty, full, count, sticky overrun, threshold and idle-timeout. Converts the receiver's level-held valid into exactly one push per received byte.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 82 ++++++++
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types, used by both the RX and TX FIFO wrappers.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_FIFO_AW     = 4;
  localparam int UART_FIFO_THRESH = 8;
  localparam int UART_TIMEOUT_CYC = 4096;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO with registered count, empty, full and level flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int AW     = UART_FIFO_AW,
  parameter int W      = UART_DATA_W,
  parameter int THRESH = UART_FIFO_THRESH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic         flush,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count,
  output logic         level,
  output logic         push,
  output logic         pop
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q, level_q;

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign push = wr_en & ~flush & (~full_q | rd_en);
  assign pop  = rd_en & ~flush & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == (AW+1)'(DEPTH));
      level_q  <= (count_d >= (AW+1)'(THRESH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one push per rising edge of rx_valid, plus overrun and idle-timeout status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int AW          = UART_FIFO_AW,
  parameter int THRESH      = UART_FIFO_THRESH,
  parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  input  logic                   flush,
  input  logic                   clr_overrun,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            count,
  output logic                   overrun,
  output logic                   level_irq,
  output logic                   rx_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          rx_valid_q;
  logic          push_req, push, pop, drop;
  logic          overrun_q, overrun_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // The receiver holds data_valid high for a whole byte time; only its rising edge is a new byte.
  assign push_req = rx_valid & ~rx_valid_q;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .W      (UART_DATA_W),
    .THRESH (THRESH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_req),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .flush   (flush),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .level   (level_irq),
    .push    (push),
    .pop     (pop)
  );

  // A byte lost to flush is deliberately not reported as an overrun.
  assign drop = push_req & full & ~rd_en & ~flush;

  always_comb begin
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;

    tmo_d = tmo_q;
    if (flush | push | pop | empty)    tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT_CYC)) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      overrun_q  <= overrun_d;
      tmo_q      <= tmo_d;
    end
  end

  assign overrun    = overrun_q;
  assign rx_timeout = (tmo_q == TW'(TIMEOUT_CYC)) & ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=8, TIMEOUT_CYC=16).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       flush;
  logic       clr_overrun;
  logic       empty, full, overrun, level_irq, rx_timeout;
  logic [4:0] count;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH       (16),
    .AW          (4),
    .THRESH      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .level_irq   (level_irq),
    .rx_timeout  (rx_timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change 1ns after an edge; outputs are sampled at the same point after the next edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rd,
                               input logic fl, input logic clr);
    rx_valid    = v;
    rx_data     = d;
    rd_en       = rd;
    flush       = fl;
    clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_level", level_irq, 0);
    checkOutput("rst_timeout", rx_timeout, 0);

    // Short pulse then a long-held valid: exactly two pushes.
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_count", count, 2);
    checkOutput("hold_head", rd_data, 8'h55);
    popByte();
    checkOutput("pop1_head", rd_data, 8'hA3);
    checkOutput("pop1_count", count, 1);
    popByte();
    checkOutput("pop2_empty", empty, 1);
    checkOutput("pop2_count", count, 0);
    popByte();
    checkOutput("underflow_count", count, 0);

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 16; i++) pushByte(8'(i));
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 16);
    checkOutput("fill_overrun", overrun, 0);
    checkOutput("fill_level", level_irq, 1);
    pushByte(8'h10);
    checkOutput("ovf_overrun", overrun, 1);
    checkOutput("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ovf_order", rd_data, 32'(i));
      popByte();
    end
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_overrun", overrun, 1);

    // Flush wins over a same-cycle push; clr_overrun clears with no drop.
    for (int i = 0; i < 5; i++) pushByte(8'h40 + 8'(i));
    checkOutput("five_count", count, 5);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_overrun", overrun, 0);

    // Full FIFO with push and pop together.
    for (int i = 0; i < 16; i++) pushByte(8'h20 + 8'(i));
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    checkOutput("fullrw_count", count, 16);
    checkOutput("fullrw_overrun", overrun, 0);
    checkOutput("fullrw_head", rd_data, 8'h21);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) popByte();
    checkOutput("fullrw_tail", rd_data, 8'hEE);
    checkOutput("fullrw_tailcnt", count, 1);
    popByte();
    checkOutput("fullrw_empty", empty, 1);

    // Threshold rises on the 8th push edge.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("lvl_rise", level_irq, (i == 7) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    popByte();
    checkOutput("lvl_fall", level_irq, 0);
    checkOutput("lvl_count", count, 7);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("lvl_flush", empty, 1);

    // Idle timeout: asserts exactly 16 edges after the push edge.
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_at_push", rx_timeout, 0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("tmo_idle", rx_timeout, (k == 16) ? 32'd1 : 32'd0);
    end
    popByte();
    checkOutput("tmo_clear", rx_timeout, 0);
    checkOutput("tmo_empty", empty, 1);

    // Asynchronous reset in the middle of filling.
    for (int i = 0; i < 3; i++) pushByte(8'h60 + 8'(i));
    clr_overrun = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("arst_empty", empty, 1);
    checkOutput("arst_count", count, 0);
    checkOutput("arst_full", full, 0);
    checkOutput("arst_level", level_irq, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rel_push_count", count, 1);
    checkOutput("rel_push_data", rd_data, 8'h3C);
    applyStimulus(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3E, 1'b0, 1'b0, 1'b0);
    checkOutput("rel_hold_count", count, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
